// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op and state
// encodings, iteration count and a magnitude helper.
package exe_muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdOp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_FIX  = 2'b11
    } mdState_t;

    localparam int         MD_ITERS     = 32;
    localparam logic [5:0] MD_ITERS_CNT = 6'(MD_ITERS);

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic [31:0] absVal(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: operand registers, 64-bit accumulator and step counter.
// One shift-add (multiply) or restoring shift-subtract (divide) step per enabled cycle.
module muldiv_core
    import exe_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic        divMode,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    output logic [63:0] acc,
    output logic        iterDone,
    output logic        bZero
);

    logic [31:0] aReg;
    logic [31:0] bReg;
    logic [5:0]  cnt;
    logic [32:0] mulSum;
    logic [32:0] divTrial;
    logic [32:0] divDiff;
    logic [63:0] accNext;

    // Multiply keeps {partial product, remaining multiplier} in acc; divide keeps
    // {remainder, dividend/quotient}. A borrow out of divDiff means restore.
    always_comb begin
        mulSum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? aReg : 32'd0)};
        divTrial = acc[63:31];
        divDiff  = divTrial - {1'b0, bReg};
        accNext  = {mulSum, acc[31:1]};
        if (divMode) begin
            if (divDiff[32])
                accNext = {divTrial[31:0], acc[30:0], 1'b0};
            else
                accNext = {divDiff[31:0], acc[30:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aReg <= '0;
            bReg <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else if (load) begin
            aReg <= opA;
            bReg <= opB;
            acc  <= {32'd0, (divMode ? opA : opB)};
            cnt  <= '0;
        end else if (step) begin
            acc <= accNext;
            cnt <= cnt + 6'd1;
        end
    end

    assign iterDone = (cnt == MD_ITERS_CNT);
    assign bZero    = (bReg == 32'd0);

endmodule

// File: rtl/exe_muldiv.sv
// EX-stage multiply/divide unit with architectural HI/LO registers.
// Control FSM around muldiv_core; results are sign-corrected in FIX.
module exe_muldiv
    import exe_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] exe_RFRD1,
    input  logic [31:0] exe_RFRD2,
    input  logic        md_start,
    input  logic [1:0]  md_op,
    input  logic        md_flush,
    input  logic        hilo_rd,
    input  logic        hi_we,
    input  logic        lo_we,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        md_busy,
    output logic        md_done,
    output logic        stall_req
);

    mdState_t    state;
    logic        divOp;
    logic        negQ;
    logic        negR;
    logic        opSigned;
    logic        load;
    logic        step;
    logic        divMode;
    logic        iterDone;
    logic        bZero;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [63:0] acc;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fixHi;
    logic [31:0] fixLo;

    always_comb begin
        opSigned = isSignedOp(md_op);
        opA      = opSigned ? absVal(exe_RFRD1) : exe_RFRD1;
        opB      = opSigned ? absVal(exe_RFRD2) : exe_RFRD2;
        load     = (state == ST_IDLE) && md_start && !md_flush;
        step     = ((state == ST_MUL) || (state == ST_DIV)) && !iterDone && !md_flush;
        divMode  = (state == ST_IDLE) ? md_op[1] : (state == ST_DIV);
    end

    muldiv_core uCore (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .step     (step),
        .divMode  (divMode),
        .opA      (opA),
        .opB      (opB),
        .acc      (acc),
        .iterDone (iterDone),
        .bZero    (bZero)
    );

    // Divide by zero leaves the remainder equal to |A|, so only LO needs overriding.
    always_comb begin
        prod  = negQ ? (~acc + 64'd1) : acc;
        quo   = acc[31:0];
        rem   = acc[63:32];
        fixHi = prod[63:32];
        fixLo = prod[31:0];
        if (divOp) begin
            fixHi = negR ? (~rem + 32'd1) : rem;
            fixLo = bZero ? 32'hFFFF_FFFF : (negQ ? (~quo + 32'd1) : quo);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            hi      <= '0;
            lo      <= '0;
            md_done <= 1'b0;
            divOp   <= 1'b0;
            negQ    <= 1'b0;
            negR    <= 1'b0;
        end else begin
            md_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hi_we) hi <= exe_RFRD1;
                    if (lo_we) lo <= exe_RFRD1;
                    if (md_start && !md_flush) begin
                        divOp <= md_op[1];
                        negQ  <= opSigned & (exe_RFRD1[31] ^ exe_RFRD2[31]);
                        negR  <= opSigned & exe_RFRD1[31];
                        state <= md_op[1] ? ST_DIV : ST_MUL;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (md_flush)
                        state <= ST_IDLE;
                    else if (iterDone)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    if (!md_flush) begin
                        hi      <= fixHi;
                        lo      <= fixLo;
                        md_done <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md_busy   = (state != ST_IDLE);
    assign stall_req = (state != ST_IDLE) && (md_start || hilo_rd || hi_we || lo_we);

endmodule

// File: tb/tb_exe_muldiv.sv
// Scoreboard bench for exe_muldiv: expected HI/LO queued at issue, checked on md_done.
module tb_exe_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] exe_RFRD1 = '0;
    logic [31:0] exe_RFRD2 = '0;
    logic        md_start = 1'b0;
    logic [1:0]  md_op = '0;
    logic        md_flush = 1'b0;
    logic        hilo_rd = 1'b0;
    logic        hi_we = 1'b0;
    logic        lo_we = 1'b0;
    logic [31:0] hi, lo;
    logic        md_busy, md_done, stall_req;

    int          nVec  = 0;
    int          nFail = 0;
    logic [63:0] expQ[$];

    exe_muldiv dut (
        .clk(clk), .rst(rst), .exe_RFRD1(exe_RFRD1), .exe_RFRD2(exe_RFRD2),
        .md_start(md_start), .md_op(md_op), .md_flush(md_flush), .hilo_rd(hilo_rd),
        .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo), .md_busy(md_busy),
        .md_done(md_done), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    // Reference model: {HI, LO} from 64-bit host arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        if (op[1] && b == 32'd0) return {a, 32'hFFFF_FFFF};
        case (op)
            2'b00: begin p = sa * sb; return p; end
            2'b01: begin p = ua * ub; return p; end
            2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
            default: begin q = ua / ub; r = ua % ub; return {r[31:0], q[31:0]}; end
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (md_done === 1'b1) begin
            nVec++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("FAIL unexpected_done: md_done=1 hi=%h lo=%h, required no completion", hi, lo);
            end else begin
                logic [63:0] expV;
                expV = expQ.pop_front();
                if ({hi, lo} !== expV) begin
                    nFail++;
                    $display("FAIL result: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, expV[63:32], expV[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input bit expectResult);
        exe_RFRD1 = a;
        exe_RFRD2 = b;
        md_op     = op;
        md_start  = 1'b1;
        if (expectResult) expQ.push_back(model(op, a, b));
        tick();
        md_start  = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit busyOk);
        lat = -1;
        busyOk = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (md_done === 1'b1) begin
                lat = k;
                break;
            end
            if (md_busy !== 1'b1) busyOk = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        nVec++;
        if ({hi, lo, md_busy, md_done, stall_req} !== 67'd0) begin
            nFail++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b stall=%b, required all 0", hi, lo, md_busy, md_done, stall_req);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mult();
        int lat;
        bit busyOk;
        start_op(2'b00, 32'hFFFF_FFFE, 32'd3, 1'b1);
        nVec++;
        if (md_busy !== 1'b1) begin nFail++; $display("FAIL mult_busy_start: got %b, required 1", md_busy); end
        wait_done(lat, busyOk);
        nVec++;
        if (lat !== 34 || !busyOk) begin nFail++; $display("FAIL mult_latency: got %0d cycles busyOk=%0d, required 34 and 1", lat, busyOk); end
        nVec++;
        if ({hi, lo, md_busy} !== {64'hFFFF_FFFF_FFFF_FFFA, 1'b0}) begin
            nFail++;
            $display("FAIL mult_neg: got hi=%h lo=%h busy=%b, required hi=ffffffff lo=fffffffa busy=0", hi, lo, md_busy);
        end
        tick();
        nVec++;
        if (md_done !== 1'b0) begin nFail++; $display("FAIL done_pulse_width: got %b, required 0", md_done); end
    endtask

    task automatic test_div();
        int lat;
        bit busyOk;
        start_op(2'b11, 32'd100, 32'd7, 1'b1);
        wait_done(lat, busyOk);
        nVec++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin nFail++; $display("FAIL divu_100_7: got hi=%h lo=%h, required hi=2 lo=e", hi, lo); end
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_done(lat, busyOk);
        nVec++;
        if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 34) begin
            nFail++;
            $display("FAIL div_m7_2: got hi=%h lo=%h lat=%0d, required hi=ffffffff lo=fffffffd lat=34", hi, lo, lat);
        end
    endtask

    task automatic test_div_edge();
        int lat;
        bit busyOk;
        start_op(2'b10, 32'd5, 32'd0, 1'b1);
        wait_done(lat, busyOk);
        nVec++;
        if ({hi, lo} !== {32'd5, 32'hFFFF_FFFF} || lat !== 34) begin
            nFail++;
            $display("FAIL div_by_zero: got hi=%h lo=%h lat=%0d, required hi=5 lo=ffffffff lat=34", hi, lo, lat);
        end
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(lat, busyOk);
        nVec++;
        if ({hi, lo} !== {32'd0, 32'h8000_0000}) begin
            nFail++;
            $display("FAIL div_overflow: got hi=%h lo=%h, required hi=0 lo=80000000", hi, lo);
        end
        start_op(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b1);
        wait_done(lat, busyOk);
        start_op(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b1);
        wait_done(lat, busyOk);
    endtask

    task automatic test_stall_hilo_rd();
        bit stallOk = 1'b1;
        int lat = -1;
        start_op(2'b01, 32'h0001_2345, 32'h0000_6789, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            if (k == 10) hilo_rd = 1'b1;
            if (k == 12) begin
                exe_RFRD1 = 32'd1; exe_RFRD2 = 32'd1; md_op = 2'b11; md_start = 1'b1;
            end
            if (k == 13) md_start = 1'b0;
            tick();
            if (md_done === 1'b1) begin lat = k; break; end
            if (k >= 10 && stall_req !== 1'b1) stallOk = 1'b0;
        end
        nVec++;
        if (!stallOk || lat !== 34) begin nFail++; $display("FAIL hilo_rd_stall: got stallOk=%0d lat=%0d, required 1 and 34", stallOk, lat); end
        nVec++;
        if (stall_req !== 1'b0) begin nFail++; $display("FAIL stall_release: got %b in IDLE with hilo_rd=1, required 0", stall_req); end
        hilo_rd = 1'b0;
        repeat (40) tick();
        nVec++;
        if (md_busy !== 1'b0) begin nFail++; $display("FAIL busy_start_ignored: got busy=%b, required 0", md_busy); end
    endtask

    task automatic test_flush();
        logic [63:0] saved;
        saved = {hi, lo};
        start_op(2'b11, 32'd1000, 32'd3, 1'b0);
        repeat (19) tick();
        md_flush = 1'b1;
        tick();
        md_flush = 1'b0;
        nVec++;
        if ({md_busy, hi, lo} !== {1'b0, saved}) begin
            nFail++;
            $display("FAIL flush_abort: got busy=%b hi=%h lo=%h, required busy=0 hi=%h lo=%h", md_busy, hi, lo, saved[63:32], saved[31:0]);
        end
        repeat (40) tick();
        exe_RFRD1 = 32'd9; exe_RFRD2 = 32'd4; md_op = 2'b00;
        md_start = 1'b1; md_flush = 1'b1;
        tick();
        md_start = 1'b0; md_flush = 1'b0;
        nVec++;
        if (md_busy !== 1'b0) begin nFail++; $display("FAIL flush_beats_start: got busy=%b, required 0", md_busy); end
        repeat (40) tick();
        nVec++;
        if ({hi, lo} !== saved) begin nFail++; $display("FAIL flush_hilo_hold: got hi=%h lo=%h, required hi=%h lo=%h", hi, lo, saved[63:32], saved[31:0]); end
    endtask

    task automatic test_reset_midop();
        start_op(2'b00, 32'd7, 32'd9, 1'b0);
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        nVec++;
        if ({hi, lo, md_busy, md_done} !== 66'd0) begin
            nFail++;
            $display("FAIL reset_midop: got hi=%h lo=%h busy=%b done=%b, required all 0", hi, lo, md_busy, md_done);
        end
        tick();
        rst = 1'b1;
        repeat (40) tick();
        nVec++;
        if ({hi, lo, md_busy} !== 65'd0) begin
            nFail++;
            $display("FAIL reset_no_resume: got hi=%h lo=%h busy=%b, required all 0", hi, lo, md_busy);
        end
    endtask

    task automatic test_mthi();
        bit holdOk = 1'b1;
        int lat = -1;
        exe_RFRD1 = 32'h1234_5678; hi_we = 1'b1;
        tick();
        hi_we = 1'b0;
        exe_RFRD1 = 32'h0BAD_F00D; lo_we = 1'b1;
        tick();
        lo_we = 1'b0;
        nVec++;
        if ({hi, lo} !== {32'h1234_5678, 32'h0BAD_F00D}) begin
            nFail++;
            $display("FAIL mthi_mtlo_idle: got hi=%h lo=%h, required hi=12345678 lo=0badf00d", hi, lo);
        end
        start_op(2'b01, 32'd2, 32'd3, 1'b1);
        for (int k = 1; k <= 60; k++) begin
            if (k == 5) begin exe_RFRD1 = 32'hDEAD_BEEF; hi_we = 1'b1; end
            tick();
            if (md_done === 1'b1) begin lat = k; break; end
            if (k >= 5 && (stall_req !== 1'b1 || hi !== 32'h1234_5678)) holdOk = 1'b0;
        end
        nVec++;
        if (!holdOk || lat !== 34) begin nFail++; $display("FAIL mthi_busy_hold: got holdOk=%0d lat=%0d, required 1 and 34", holdOk, lat); end
        tick();
        hi_we = 1'b0;
        nVec++;
        if (hi !== 32'hDEAD_BEEF) begin nFail++; $display("FAIL mthi_after_idle: got hi=%h, required deadbeef", hi); end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit busyOk;
        logic [1:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 10; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i == 3) ? 32'd0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            if (i == 5) a = 32'h8000_0000;
            start_op(op, a, b, 1'b1);
            wait_done(lat, busyOk);
            nVec++;
            if (lat !== 34 || !busyOk) begin nFail++; $display("FAIL b2b_latency[%0d]: got %0d busyOk=%0d, required 34 and 1", i, lat, busyOk); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_edge();
        test_stall_hilo_rd();
        test_flush();
        test_reset_midop();
        test_mthi();
        test_back_to_back();
        repeat (3) tick();
        nVec++;
        if (expQ.size() !== 0) begin nFail++; $display("FAIL pending_results: got %0d outstanding, required 0", expQ.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 The block SHALL have these ports: clk  in  1  single clock, rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 exe_RFRD1  in  32  operand A (dividend/multiplicand) from ID/EX register.
REQ-004 exe_RFRD2  in  32  operand B (divisor/multiplier) from ID/EX register.
REQ-005 md_start  in  1  one-cycle request to begin an operation.
REQ-006 md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with md_start.
REQ-007 md_flush  in  1  abort any in-flight operation.
REQ-008 hilo_rd  in  1  EX instruction reads HI/LO (MFHI/MFLO).
REQ-009 hi_we, lo_we  in  1 each  direct write of HI/LO (MTHI/MTLO) from exe_RFRD1.
REQ-010 hi, lo  out  32 each  architectural HI/LO registers.
REQ-011 md_busy  out  1  high whenever the FSM is not IDLE.
REQ-012 md_done  out  1  one-cycle pulse in the cycle HI/LO take a new result.
REQ-013 stall_req  out  1  combinational pipeline stall request toward IF/ID and ID/EX.

Function
REQ-014 The FSM SHALL have states IDLE, MUL, DIV, FIX; reset state IDLE.
REQ-015 IDLE: md_start=1 SHALL latch |A|, |B| (signed ops) or A, B (unsigned), the result signs, and md_op, clear the 6-bit iteration counter, and go to MUL (op 0x) or DIV (op 1x).
REQ-016 MUL SHALL do one shift-add step per cycle for exactly 32 cycles into a 64-bit accumulator, then go to FIX.
REQ-017 DIV SHALL do one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-018 FIX SHALL apply sign correction, write HI/LO, pulse md_done, and return to IDLE.
REQ-019 Latency: md_start sampled at edge N SHALL give new hi/lo and md_done=1 after edge N+34, with md_busy high from edge N+1 to edge N+34.
REQ-020 Signed multiply SHALL give the 64-bit two's-complement product: HI = bits 63:32, LO = bits 31:0.
REQ-021 Signed divide SHALL give quotient sign = sign(A) xor sign(B) and remainder sign = sign(A); LO = quotient, HI = remainder.
REQ-022 DIV/DIVU with B=0 SHALL finish with normal latency and give LO=32'hFFFFFFFF, HI=A unmodified.
REQ-023 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give LO=32'h80000000, HI=0.
REQ-024 md_start while not IDLE SHALL be ignored by the FSM.
REQ-025 stall_req SHALL equal (state != IDLE) AND (md_start OR hilo_rd OR hi_we OR lo_we).
REQ-026 In IDLE, hi_we/lo_we SHALL load exe_RFRD1 into HI/LO on the next edge; while busy these writes SHALL be held off by stall_req and not performed.
REQ-027 If md_flush and md_start are asserted together in IDLE, md_flush SHALL win and no operation SHALL start.
REQ-028 md_flush in MUL/DIV/FIX SHALL return the FSM to IDLE on the next edge with HI/LO unchanged and no md_done.
REQ-029 hi/lo SHALL change only via FIX or via a direct write in IDLE.

Reset
REQ-030 rst=0 SHALL immediately force: state IDLE, hi=0, lo=0, md_busy=0, md_done=0, counter=0, accumulators=0.
REQ-031 Reset during MUL/DIV SHALL discard the operation with no md_done; operation SHALL resume only on a fresh md_start after reset deasserts.

Structure
REQ-032 The md_op encodings, FSM state encodings, and the iteration count constant (32) SHALL live in the shared CPU package.
REQ-033 The iterative datapath SHALL be one sub-module, muldiv_core (operand registers, accumulator, counter), controlled by the FSM in exe_muldiv.

Verification
REQ-034 MULT with A=32'hFFFFFFFE (-2), B=3 -> after 34 cycles HI=32'hFFFFFFFF, LO=32'hFFFFFFFA, one md_done pulse.
REQ-035 DIVU with A=100, B=7 -> LO=14, HI=2; DIV with A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-036 DIV with A=5, B=0 -> LO=32'hFFFFFFFF, HI=5; DIV of 32'h80000000 by -1 -> LO=32'h80000000, HI=0.
REQ-037 hilo_rd=1 at cycle 10 of a MULTU -> stall_req=1 until FSM is IDLE; second md_start while busy -> ignored, result is from the first operation.
REQ-038 md_flush at cycle 20 of DIVU -> IDLE next cycle, HI/LO hold the prior values, no md_done; rst=0 at cycle 5 -> all outputs 0 immediately.
REQ-039 MTHI with exe_RFRD1=32'h12345678 in IDLE -> HI=32'h12345678 next cycle; the same write while busy -> stall_req=1 and HI unchanged until IDLE.
